// File: rtl/one_hot_encoder_stream.sv
// one_hot_encoder_stream: streaming one-hot to binary encoder with a
// 2-entry output buffer and a saturating malformed-word counter.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake, in_onehot is the N-bit word
//   out_valid/out_ready downstream handshake for the buffer head
//   out_code, out_err   binary index and malformed flag of the head entry
//   err_count, clr_err  saturating malformed-word count and its clear
module one_hot_encoder_stream #(
  parameter int N         = 8,
  parameter int W         = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_onehot,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_code,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] head_code;
  logic [W-1:0] tail_code;
  logic         head_err;
  logic         tail_err;
  logic         push;
  logic         pop;
  logic [W-1:0] enc_code;
  logic         enc_err;

  // in_ready looks only at registered occupancy, never at out_ready.
  assign in_ready  = !rst && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Scan from the top down so the lowest set bit wins on multi-hot words.
  always_comb begin
    enc_code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_onehot[i]) enc_code = W'(i);
    end
  end

  // x & (x-1) is nonzero exactly when more than one bit is set.
  assign enc_err = (in_onehot == '0) ||
                   ((in_onehot & (in_onehot - N'(1))) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head_code <= '0;
      head_err  <= 1'b0;
      tail_code <= '0;
      tail_err  <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head_code <= enc_code;
            head_err  <= enc_err;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_code <= enc_code;
            head_err  <= enc_err;
          end else if (push) begin
            tail_code <= enc_code;
            tail_err  <= enc_err;
            state     <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_code <= tail_code;
            head_err  <= tail_err;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      err_count <= '0;
    end else if (push && enc_err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

  // Stale head contents are masked so an empty buffer always reads as zero.
  assign out_code = out_valid ? head_code : '0;
  assign out_err  = out_valid ? head_err  : 1'b0;

endmodule

// File: tb/tb_one_hot_encoder_stream.sv
// tb_one_hot_encoder_stream: directed bench for one_hot_encoder_stream.
// A second instance with a 2-bit counter shares the stimulus.
module tb_one_hot_encoder_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_onehot;
  logic       out_ready;
  logic       clr_err;

  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_code;
  logic       out_err;
  logic [7:0] err_count;

  logic       s_in_ready;
  logic       s_out_valid;
  logic [2:0] s_out_code;
  logic       s_out_err;
  logic [1:0] s_err_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  one_hot_encoder_stream #(.N(8), .W(3), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_onehot (in_onehot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_err   (out_err),
    .err_count (err_count),
    .clr_err   (clr_err)
  );

  one_hot_encoder_stream #(.N(8), .W(3), .ERR_CNT_W(2)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_onehot (in_onehot),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_code  (s_out_code),
    .out_err   (s_out_err),
    .err_count (s_err_count),
    .clr_err   (clr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_onehot = 8'h00;
    out_ready = 1'b0;
    clr_err = 1'b0;
    tick();
    tests++;
    if (in_ready !== 1'b0) begin
      $display("FAIL reset_in_ready got %0b want 0", in_ready);
      fails++;
    end
    tick();
    rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_code !== 3'd0 || out_err !== 1'b0) begin
      $display("FAIL reset_out got v=%0b c=%0d e=%0b want 0 0 0",
               out_valid, out_code, out_err);
      fails++;
    end
    tests++;
    if (err_count !== 8'd0 || in_ready !== 1'b1) begin
      $display("FAIL reset_cnt_rdy got cnt=%0d rdy=%0b want 0 1",
               err_count, in_ready);
      fails++;
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_onehot = 8'h01 << i;
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_code !== 3'(i) || out_err !== 1'b0) begin
        $display("FAIL stream_%0d got v=%0b c=%0d e=%0b want 1 %0d 0",
                 i, out_valid, out_code, out_err, i);
        fails++;
      end
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b0 || err_count !== 8'd0) begin
      $display("FAIL stream_drain got v=%0b cnt=%0d want 0 0",
               out_valid, err_count);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_onehot = 8'h04;
    tick();
    in_onehot = 8'h10;
    tick();
    tests++;
    if (in_ready !== 1'b0 || out_code !== 3'd2) begin
      $display("FAIL bp_full got rdy=%0b c=%0d want 0 2", in_ready, out_code);
      fails++;
    end
    in_onehot = 8'h01;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_code !== 3'd2 || in_ready !== 1'b0) begin
      $display("FAIL bp_hold got v=%0b c=%0d rdy=%0b want 1 2 0",
               out_valid, out_code, in_ready);
      fails++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_code !== 3'd4 || in_ready !== 1'b1) begin
      $display("FAIL bp_pop1 got v=%0b c=%0d rdy=%0b want 1 4 1",
               out_valid, out_code, in_ready);
      fails++;
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      $display("FAIL bp_third_dropped got v=%0b want 0", out_valid);
      fails++;
    end
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_onehot = 8'h00;
    tick();
    tests++;
    if (out_code !== 3'd0 || out_err !== 1'b1 || err_count !== 8'd1) begin
      $display("FAIL err_zero got c=%0d e=%0b cnt=%0d want 0 1 1",
               out_code, out_err, err_count);
      fails++;
    end
    in_onehot = 8'h28;
    tick();
    tests++;
    if (out_code !== 3'd3 || out_err !== 1'b1 || err_count !== 8'd2) begin
      $display("FAIL err_multi got c=%0d e=%0b cnt=%0d want 3 1 2",
               out_code, out_err, err_count);
      fails++;
    end
    in_valid = 1'b0;
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tests++;
    if (err_count !== 8'd0 || s_err_count !== 2'd0 || out_valid !== 1'b0) begin
      $display("FAIL err_clear got cnt=%0d s=%0d v=%0b want 0 0 0",
               err_count, s_err_count, out_valid);
      fails++;
    end
  endtask

  task automatic test_saturate();
    logic [1:0] want_s [5];
    want_s[0] = 2'd1;
    want_s[1] = 2'd2;
    want_s[2] = 2'd3;
    want_s[3] = 2'd3;
    want_s[4] = 2'd3;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_onehot = (i % 2 == 0) ? 8'hff : 8'h00;
      tick();
      tests++;
      if (s_err_count !== want_s[i] || err_count !== 8'(i + 1)) begin
        $display("FAIL sat_%0d got s=%0d cnt=%0d want %0d %0d",
                 i, s_err_count, err_count, want_s[i], i + 1);
        fails++;
      end
    end
    in_onehot = 8'h06;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (s_err_count !== 2'd0 || err_count !== 8'd0) begin
      $display("FAIL sat_clr_wins got s=%0d cnt=%0d want 0 0",
               s_err_count, err_count);
      fails++;
    end
    tests++;
    if (out_code !== 3'd1 || out_err !== 1'b1) begin
      $display("FAIL sat_last_head got c=%0d e=%0b want 1 1",
               out_code, out_err);
      fails++;
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_onehot = 8'h03;
    tick();
    in_onehot = 8'h80;
    tick();
    in_valid = 1'b0;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || err_count !== 8'd1) begin
      $display("FAIL flush_fill got rdy=%0b v=%0b cnt=%0d want 0 1 1",
               in_ready, out_valid, err_count);
      fails++;
    end
    rst = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || out_code !== 3'd0) begin
      $display("FAIL flush_rst got v=%0b cnt=%0d c=%0d want 0 0 0",
               out_valid, err_count, out_code);
      fails++;
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b0) begin
        $display("FAIL flush_stale_%0d got v=%0b c=%0d want v=0",
                 i, out_valid, out_code);
        fails++;
      end
    end
    in_valid = 1'b1;
    in_onehot = 8'h20;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_code !== 3'd5 || out_err !== 1'b0) begin
      $display("FAIL flush_resume got v=%0b c=%0d e=%0b want 1 5 0",
               out_valid, out_code, out_err);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_errors();
    test_saturate();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/one_hot_encoder_stream.md
Name: one_hot_encoder_stream

Overview:
- Streaming N:log2(N) one-hot-to-binary encoder. It is the inverse of the team's 3:8 one-hot decoder.
- Accepts one-hot words over a valid/ready handshake and emits the binary index plus a per-word validity flag.
- Output is buffered in a 2-entry FIFO, so backpressure never drops data.
- Keeps a saturating count of malformed (zero-hot or multi-hot) words. It sits between decoder-style select logic and downstream consumers that need the compact index.

Parameters:
- N, 8, one-hot input width; N >= 2.
- W, 3, output code width; must equal ceil(log2(N)).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle.
- in_onehot  input  N  one-hot input word.
- out_valid  output  1  head of buffer holds a result.
- out_ready  input  1  downstream consumes the head this cycle.
- out_code  output  W  binary index of the head entry.
- out_err  output  1  head entry came from a malformed input word.
- err_count  output  ERR_CNT_W  number of malformed words accepted, saturating.
- clr_err  input  1  synchronous clear of err_count.

Behaviour:
- Reset (rst high at a clk edge):
  - Buffer occupancy goes to 0, so out_valid=0, out_code=0 and out_err=0.
  - err_count=0.
  - in_ready is held at 0 while rst is high.
- Handshake:
  - Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
  - in_ready = !rst && (occupancy < 2). It is derived from registered occupancy only and has no combinational path from out_ready.
  - out_valid = (occupancy != 0).
  - out_code and out_err are taken from the head entry and stay stable while out_valid && !out_ready.
- Latency: a word pushed at edge k is visible on out_valid/out_code at edge k+1 when the buffer was empty. There is no combinational in-to-out path.
- Occupancy state machine, with states EMPTY(0), ONE(1), FULL(2):
  - push only: +1.
  - pop only: -1.
  - push and pop together in ONE: stays ONE, and the new word becomes the head on the next cycle.
  - in FULL, no push is possible (in_ready=0). A pop goes to ONE, and in_ready rises on the following cycle.
  - pop from EMPTY is impossible (out_valid=0).
- Encoding of in_onehot at push:
  - exactly one bit i set: code = i, err = 0.
  - zero bits set: code = 0, err = 1.
  - two or more bits set: code = index of the lowest set bit, err = 1.
- Indices are unsigned, and bit 0 maps to code 0.
- Error counter:
  - Increments by 1 on each push whose err = 1.
  - Holds at 2^ERR_CNT_W - 1 instead of wrapping.
  - clr_err sets it to 0 on the next edge. If clr_err coincides with an erroneous push, clear wins and the result is 0.
  - Popping does not affect the count.
- in_onehot is ignored when no push occurs.
- Reset mid-operation flushes all buffered entries, without producing an output beat, and clears err_count.

Test Plan:
- rst high for 2 cycles, then low, with in_valid=0 -> out_valid=0, out_code=0, out_err=0, err_count=0 and in_ready=1 on the first cycle after release.
- out_ready=1; push 8'h01, 8'h02, ... 8'h80 on consecutive cycles -> out_code goes 0..7 one cycle after each push, out_err=0 throughout, err_count=0.
- out_ready=0; push 8'h04 then 8'h10 -> in_ready=0 after the 2nd push and a 3rd in_valid is not accepted. Raise out_ready -> out_code 2 then 4 in order, and in_ready returns to 1 one cycle after the first pop.
- Push 8'h00 and then 8'h28 -> outputs (code 0, err 1) and (code 3, err 1), and err_count=2.
- ERR_CNT_W=2; push 5 error words -> err_count goes 1, 2, 3, 3, 3. Then pulse clr_err on the same cycle as a 6th error push -> err_count=0.
- Fill the buffer (FULL) with out_ready=0, then assert rst for 1 cycle -> out_valid=0, err_count=0 and neither stale entry ever appears on the output.
